// File: rtl/branch_pkg.sv
// Shared types and constants for the branch redirect controller.
package branch_pkg;

    typedef enum logic [2:0] {
        BT_BEQ  = 3'd0,
        BT_BNE  = 3'd1,
        BT_BLT  = 3'd2,
        BT_BGE  = 3'd3,
        BT_BLTU = 3'd4,
        BT_BGEU = 3'd5,
        BT_JAL  = 3'd6,
        BT_NONE = 3'd7
    } br_type_t;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } redir_state_t;

    localparam logic [2:0] BR_NONE   = 3'h7;
    localparam logic [1:0] BHT_RESET = 2'b01;

endpackage

// File: rtl/branch_redirect_ctrl_bht.sv
// Branch history table of 2-bit saturating counters; combinational read, single update port.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    logic [1:0] cnt_q [2**IDX_W];
    logic [1:0] cnt_d;

    assign rd_taken_o = cnt_q[rd_idx_i][1];

    // Saturate at strongly taken (3) and strongly not-taken (0).
    always_comb begin
        cnt_d = cnt_q[upd_idx_i];
        if (upd_taken_i && cnt_d != 2'b11)
            cnt_d = cnt_d + 2'b01;
        else if (!upd_taken_i && cnt_d != 2'b00)
            cnt_d = cnt_d - 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**IDX_W; i++)
                cnt_q[i] <= BHT_RESET;
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves DE control flow, issues a held redirect to fetch and flushes the wrong-path slot.
// Optional dynamic prediction with a 2-bit BHT when BRANCH_PRED_EN is defined.
module branch_redirect_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CNT_W     = 32,
    parameter int BHT_IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid_i,
    input  logic [2:0]       br_type_i,
    input  logic             br_taken_i,
    input  logic [XLEN-1:0]  br_pc_i,
    input  logic [XLEN-1:0]  br_target_i,
    input  logic             fetch_ready_i,
`ifdef BRANCH_PRED_EN
    input  logic [XLEN-1:0]  fetch_pc_i,
    input  logic             pred_taken_i,
    output logic             pred_taken_o,
`endif
    output logic             redirect_valid_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             flush_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o,
    output logic             dbg_state_o
);

    // Handshake: redirect_valid_o rises with REDIRECT and holds with a stable
    // redirect_pc_o until a cycle where fetch_ready_i is high; that edge completes it.
    redir_state_t     state_q;
    logic             redirect_valid_q;
    logic [XLEN-1:0]  redirect_pc_q;
    logic             misalign_q;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] taken_cnt_q;

    logic             resolve;
    logic             taken;
    logic             need_redir;
    logic [XLEN-1:0]  redirect_pc_d;
    logic             fire;
    logic             bad_target;

    assign resolve = (state_q == IDLE) && br_valid_i && (br_type_i != BR_NONE);
    assign taken   = (br_type_i == BT_JAL) || br_taken_i;

`ifdef BRANCH_PRED_EN
    logic pred_eff;

    // Jumps are treated as predicted taken; only conditional branches train the table.
    assign pred_eff      = (br_type_i == BT_JAL) || pred_taken_i;
    assign need_redir    = taken != pred_eff;
    assign redirect_pc_d = taken ? br_target_i : br_pc_i + XLEN'(4);

    bht_2bit #(.IDX_W(BHT_IDX_W)) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx_i    (fetch_pc_i[BHT_IDX_W+1:2]),
        .rd_taken_o  (pred_taken_o),
        .upd_en_i    (resolve && (br_type_i != BT_JAL)),
        .upd_idx_i   (br_pc_i[BHT_IDX_W+1:2]),
        .upd_taken_i (br_taken_i)
    );
`else
    logic unused_pc;

    assign unused_pc     = ^{br_pc_i, {BHT_IDX_W{1'b0}}};
    assign need_redir    = taken;
    assign redirect_pc_d = br_target_i;
`endif

    assign fire       = resolve && need_redir && (redirect_pc_d[1:0] == 2'b00);
    assign bad_target = resolve && need_redir && (redirect_pc_d[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            misalign_q       <= 1'b0;
            branch_cnt_q     <= '0;
            taken_cnt_q      <= '0;
        end else begin
            misalign_q <= bad_target;
            if (resolve)
                branch_cnt_q <= branch_cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        state_q          <= REDIRECT;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= redirect_pc_d;
                        taken_cnt_q      <= taken_cnt_q + 1'b1;
                    end
                end
                REDIRECT: begin
                    if (fetch_ready_i) begin
                        state_q          <= IDLE;
                        redirect_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The wrong-path slot is killed in the resolving cycle and for every held cycle.
    assign flush_o          = fire || (state_q == REDIRECT);
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign misalign_o       = misalign_q;
    assign branch_cnt_o     = branch_cnt_q;
    assign taken_cnt_o      = taken_cnt_q;
    assign dbg_state_o      = state_q;

endmodule
